// File: rtl/bw_clk_seq_pkg.sv
// Shared definitions for the JBI JBus clock-cluster reset/clock-enable sequencer.
package bw_clk_seq_pkg;

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_CKEN_WAIT = 3'd1,
      ST_GRST_WAIT = 3'd2,
      ST_RUN       = 3'd3,
      ST_WRST      = 3'd4,
      ST_DBG       = 3'd5,
      ST_STOPPED   = 3'd6
   } seq_state_t;

   localparam int CKEN_DLY_DEF = 8;
   localparam int GRST_DLY_DEF = 16;
   localparam int DBG_DLY_DEF  = 4;
   localparam int CNT_W_DEF    = 5;

endpackage

// File: rtl/bw_clk_seq_cnt.sv
// Loadable down-counter with zero flag; it idles at zero until the next load.
module bw_clk_seq_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bw_clk_cl_jbi_seq.sv
// Reset and clock-enable sequencer feeding the JBus cluster header.
module bw_clk_cl_jbi_seq
   import bw_clk_seq_pkg::*;
#(
   parameter int CKEN_DLY = CKEN_DLY_DEF,
   parameter int GRST_DLY = GRST_DLY_DEF,
   parameter int DBG_DLY  = DBG_DLY_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic gclk,
   input  logic arst_l,
   input  logic wrst_req,
   input  logic dbginit_req,
   input  logic clkstop_req,
   output logic cluster_cken,
   output logic grst_l,
   output logic gdbginit_l,
   output logic seq_busy,
   output logic seq_done
);

   // Counter reload values: a delay of D cycles means D-1 down to 0.
   localparam logic [CNT_W-1:0] LD_CKEN = CNT_W'(CKEN_DLY - 1);
   localparam logic [CNT_W-1:0] LD_GRST = CNT_W'(GRST_DLY - 1);
   localparam logic [CNT_W-1:0] LD_DBG  = CNT_W'(DBG_DLY - 1);

   seq_state_t       r_state;
   logic             r_cken;
   logic             r_grst_l;
   logic             r_dbg_l;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_zero;

   // Counter is reloaded on the same edge the FSM enters a timed state.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         ST_RST: begin
            w_load     = 1'b1;
            w_load_val = LD_CKEN;
         end
         ST_CKEN_WAIT: begin
            if (w_zero) begin
               w_load     = 1'b1;
               w_load_val = LD_GRST;
            end
         end
         ST_RUN: begin
            if (wrst_req) begin
               w_load     = 1'b1;
               w_load_val = LD_GRST;
            end else if (dbginit_req) begin
               w_load     = 1'b1;
               w_load_val = LD_DBG;
            end
         end
         default: begin
            w_load     = 1'b0;
            w_load_val = '0;
         end
      endcase
   end

   bw_clk_seq_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .i_clk      (gclk),
      .i_rst_n    (arst_l),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge gclk or negedge arst_l) begin
      if (!arst_l) begin
         r_state  <= ST_RST;
         r_cken   <= 1'b0;
         r_grst_l <= 1'b0;
         r_dbg_l  <= 1'b0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_RST: begin
               r_state <= ST_CKEN_WAIT;
            end
            ST_CKEN_WAIT: begin
               if (w_zero) begin
                  r_state <= ST_GRST_WAIT;
                  r_cken  <= 1'b1;
               end
            end
            ST_GRST_WAIT: begin
               if (w_zero) begin
                  r_state  <= ST_RUN;
                  r_grst_l <= 1'b1;
                  r_dbg_l  <= 1'b1;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            // Only one request is taken; lower-priority ones are dropped.
            ST_RUN: begin
               if (wrst_req) begin
                  r_state  <= ST_WRST;
                  r_grst_l <= 1'b0;
                  r_dbg_l  <= 1'b0;
                  r_busy   <= 1'b1;
               end else if (dbginit_req) begin
                  r_state <= ST_DBG;
                  r_dbg_l <= 1'b0;
                  r_busy  <= 1'b1;
               end else if (clkstop_req) begin
                  r_state <= ST_STOPPED;
                  r_cken  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_WRST: begin
               if (w_zero) begin
                  r_state  <= ST_RUN;
                  r_grst_l <= 1'b1;
                  r_dbg_l  <= 1'b1;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            ST_DBG: begin
               if (w_zero) begin
                  r_state <= ST_RUN;
                  r_dbg_l <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_STOPPED: begin
               if (!clkstop_req) begin
                  r_state <= ST_RUN;
                  r_cken  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_RST;
            end
         endcase
      end
   end

   assign cluster_cken = r_cken;
   assign grst_l       = r_grst_l;
   assign gdbginit_l   = r_dbg_l;
   assign seq_busy     = r_busy;
   assign seq_done     = r_done;

endmodule

// File: tb/tb_bw_clk_cl_jbi_seq.sv
// Directed bench for the cluster sequencer with default delays (8/16/4, 5-bit counter).
module tb_bw_clk_cl_jbi_seq;

   logic gclk;
   logic arst_l;
   logic wrst_req;
   logic dbginit_req;
   logic clkstop_req;
   logic cluster_cken;
   logic grst_l;
   logic gdbginit_l;
   logic seq_busy;
   logic seq_done;

   int n_assert;
   int n_fail;
   int edge_n;

   bw_clk_cl_jbi_seq dut (
      .gclk         (gclk),
      .arst_l       (arst_l),
      .wrst_req     (wrst_req),
      .dbginit_req  (dbginit_req),
      .clkstop_req  (clkstop_req),
      .cluster_cken (cluster_cken),
      .grst_l       (grst_l),
      .gdbginit_l   (gdbginit_l),
      .seq_busy     (seq_busy),
      .seq_done     (seq_done)
   );

   initial begin
      gclk = 1'b0;
      forever #5 gclk = ~gclk;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic cken, input logic grst,
                          input logic dbg, input logic busy, input logic done);
      chk({tag, ".cluster_cken"}, cluster_cken, cken);
      chk({tag, ".grst_l"},       grst_l,       grst);
      chk({tag, ".gdbginit_l"},   gdbginit_l,   dbg);
      chk({tag, ".seq_busy"},     seq_busy,     busy);
      chk({tag, ".seq_done"},     seq_done,     done);
      $display("%s edge=%0d cken=%b grst_l=%b gdbginit_l=%b busy=%b done=%b",
               tag, edge_n, cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done);
   endtask

   task automatic next_edge();
      @(posedge gclk);
      #1;
      edge_n++;
   endtask

   task automatic release_reset();
      @(negedge gclk);
      arst_l = 1'b1;
      edge_n = -1;
   endtask

   // Power-on: cken after edge 8, reset release/done after edge 24, done for one edge.
   task automatic power_on_run(input int last);
      for (int e = 0; e <= last; e++) begin
         next_edge();
         chk_all("poweron", e >= 8, e >= 24, e >= 24, e < 24, e == 24);
      end
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      edge_n      = -1;
      arst_l      = 1'b0;
      wrst_req    = 1'b0;
      dbginit_req = 1'b0;
      clkstop_req = 1'b0;

      // Reset held across clock edges.
      next_edge();
      next_edge();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      release_reset();
      power_on_run(26);

      // Warm reset sampled at edge 40; requests on other edges stay low.
      while (edge_n < 39) begin
         next_edge();
      end
      for (int e = 40; e <= 58; e++) begin
         wrst_req = (e == 40);
         next_edge();
         wrst_req = 1'b0;
         chk_all("wrst", 1'b1, !(e >= 40 && e <= 55), !(e >= 40 && e <= 55),
                 e >= 40 && e <= 55, e == 56);
      end

      // Debug init with clkstop at edge 60, wrst during DBG dropped,
      // clock stop taken at edge 65 and released when edge 70 samples it low.
      for (int e = 59; e <= 72; e++) begin
         dbginit_req = (e == 60);
         clkstop_req = (e >= 60 && e <= 69);
         wrst_req    = (e == 62);
         next_edge();
         chk_all("dbg_stop", !(e >= 65 && e <= 69), 1'b1, !(e >= 60 && e <= 63),
                 (e >= 60 && e <= 63) || (e >= 65 && e <= 69), e == 64);
      end
      dbginit_req = 1'b0;
      clkstop_req = 1'b0;
      wrst_req    = 1'b0;

      // Reset mid-sequence: takes effect without a clock edge.
      arst_l = 1'b0;
      next_edge();
      chk_all("reset2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_reset();
      power_on_run(12);
      @(negedge gclk);
      arst_l = 1'b0;
      #1;
      chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_edge();
      chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      release_reset();
      power_on_run(26);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
